// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_e;

  localparam logic [XLEN_DEF-1:0] DIV0_QUO = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] OVF_QUO  =
    {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/div_if.sv
// Request/response handshake bundle for the divider.
interface div_if #(
  parameter int XLEN = div_pkg::XLEN_DEF
);

  logic            req_valid;
  logic            req_ready;
  logic            req_in_1_signed;
  logic            req_in_2_signed;
  logic [XLEN-1:0] req_in_1;
  logic [XLEN-1:0] req_in_2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_quotient;
  logic [XLEN-1:0] resp_remainder;

  modport master (
    output req_valid,
    output req_in_1_signed,
    output req_in_2_signed,
    output req_in_1,
    output req_in_2,
    input  req_ready,
    input  resp_valid,
    input  resp_quotient,
    input  resp_remainder,
    output resp_ready
  );

  modport slave (
    input  req_valid,
    input  req_in_1_signed,
    input  req_in_2_signed,
    input  req_in_1,
    input  req_in_2,
    output req_ready,
    output resp_valid,
    output resp_quotient,
    output resp_remainder,
    input  resp_ready
  );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] sh;
  logic [XLEN+1:0] trial;

  assign sh    = {rem_i, quo_i[XLEN-1]};
  assign trial = sh - {2'b00, div_i};
  assign rem_o = trial[XLEN+1] ? sh[XLEN:0] : trial[XLEN:0];
  assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN+1]};

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with valid/ready handshakes.
// Define DIV_EARLY_OUT_EN to skip CALC for divide-by-zero and overflow.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  div_if.slave bus
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  rq_q, rq_d;
  logic [XLEN-1:0]  rr_q, rr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;

  logic             neg1, neg2;
  logic             div0, ovf;
  logic [XLEN-1:0]  mag1, mag2;
  logic [XLEN:0]    step_rem;
  logic [XLEN-1:0]  step_quo;

  assign neg1 = bus.req_in_1_signed & bus.req_in_1[XLEN-1];
  assign neg2 = bus.req_in_2_signed & bus.req_in_2[XLEN-1];
  assign mag1 = neg1 ? -bus.req_in_1 : bus.req_in_1;
  assign mag2 = neg2 ? -bus.req_in_2 : bus.req_in_2;
  assign div0 = (bus.req_in_2 == '0);
  assign ovf  = bus.req_in_1_signed & bus.req_in_2_signed
              & (bus.req_in_1 == OVF_QUO)
              & (bus.req_in_2 == '1);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    rq_d    = rq_q;
    rr_d    = rr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rem_d   = '0;
          quo_d   = mag1;
          dvs_d   = mag2;
          dvd_d   = bus.req_in_1;
          qneg_d  = neg1 ^ neg2;
          rneg_d  = neg1;
          div0_d  = div0;
          ovf_d   = ovf;
          cnt_d   = CNT_W'(XLEN-1);
          state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (div0 || ovf) state_d = FIXUP;
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) state_d = FIXUP;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      FIXUP: begin
        unique case (1'b1)
          div0_q: begin
            rq_d = DIV0_QUO;
            rr_d = dvd_q;
          end
          ovf_q: begin
            rq_d = OVF_QUO;
            rr_d = '0;
          end
          default: begin
            rq_d = qneg_q ? -quo_q : quo_q;
            rr_d = rneg_q ? -rem_q[XLEN-1:0]
                          : rem_q[XLEN-1:0];
          end
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      rq_q    <= '0;
      rr_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      rq_q    <= rq_d;
      rr_q    <= rr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = (state_q == DONE);
  assign bus.resp_quotient  = rq_q;
  assign bus.resp_remainder = rr_q;

endmodule
